// File: rtl/pie_rx_decoder.sv
// Tag-side PIE receiver: recovers delimiter/data-0/RTcal/TRcal, decodes data bits MSB-first
// into bytes and checks CRC-5 and CRC-16 residues at frame end.
module pie_rx_decoder #(
    parameter logic [15:0] DELIM_MIN = 16'd40,
    parameter logic [15:0] DELIM_MAX = 16'd160,
    parameter logic [15:0] MAX_CAL   = 16'd4095
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    output logic [7:0]  dbus_out,
    output logic        byte_valid,
    output logic        frame_start,
    output logic        frame_end,
    output logic        frame_err,
    output logic [15:0] frame_bits,
    output logic        query_preamble,
    output logic [15:0] rtcal_cnt,
    output logic [15:0] trcal_cnt,
    output logic        crc5_ok,
    output logic        crc16_ok
);

    typedef enum logic [2:0] {
        S_IDLE, S_DELIM, S_TARI0, S_RTCAL, S_CAL, S_DATA, S_ERROR
    } state_t;

    state_t      r_state, w_next;
    logic        r_sync1, r_sync2, r_prev;
    logic        w_rise, w_fall;
    logic [15:0] r_per, r_low, r_hi, r_p0;
    logic [7:0]  r_byte;
    logic [2:0]  r_bitcnt;
    logic [4:0]  r_crc5;
    logic [15:0] r_crc16;

    logic        w_start, w_err, w_end, w_bit_en, w_bit, w_trcal, w_rtcal_ld, w_p0_ld;
    logic        w_fb5, w_fb16;
    logic [7:0]  w_part;

    assign w_rise = r_sync2 & ~r_prev;
    assign w_fall = ~r_sync2 & r_prev;

    // Synchronizer presets to idle-high so reset release never creates a false edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
            r_per   <= '0;
            r_low   <= '0;
            r_hi    <= '0;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (w_rise)                 r_per <= 16'd1;
            else if (r_per != 16'hFFFF) r_per <= r_per + 16'd1;
            if (w_fall)                                r_low <= 16'd1;
            else if (!r_sync2 && r_low != 16'hFFFF)    r_low <= r_low + 16'd1;
            if (!r_sync2)               r_hi <= '0;
            else if (r_hi != 16'hFFFF)  r_hi <= r_hi + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_fall) w_next = S_DELIM;
            S_DELIM: begin
                if (w_rise)
                    w_next = (r_low >= DELIM_MIN && r_low <= DELIM_MAX) ? S_TARI0 : S_ERROR;
                else if (r_low >= DELIM_MAX)
                    w_next = S_ERROR;
            end
            S_TARI0: begin
                if (r_per >= MAX_CAL) w_next = S_ERROR;
                else if (w_rise)      w_next = S_RTCAL;
            end
            S_RTCAL: begin
                if (w_rise)
                    w_next = (r_per > r_p0 && r_per < MAX_CAL) ? S_CAL : S_ERROR;
                else if (r_per >= MAX_CAL)
                    w_next = S_ERROR;
            end
            S_CAL: begin
                if (w_rise)                                    w_next = S_DATA;
                else if ({2'b00, r_per} >= {rtcal_cnt, 2'b00}) w_next = S_ERROR;
            end
            S_DATA: begin
                if (!w_rise && r_per == rtcal_cnt) w_next = r_sync2 ? S_IDLE : S_ERROR;
            end
            S_ERROR: if (r_hi >= DELIM_MAX) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_start    = (r_state == S_DELIM) && (w_next == S_TARI0);
        w_err      = (r_state != S_ERROR) && (w_next == S_ERROR);
        w_end      = (r_state == S_DATA) && !w_rise && (r_per == rtcal_cnt) && r_sync2;
        w_p0_ld    = (r_state == S_TARI0) && w_rise;
        w_rtcal_ld = (r_state == S_RTCAL) && (w_next == S_CAL);
        w_trcal    = (r_state == S_CAL) && w_rise && (r_per > rtcal_cnt);
        w_bit_en   = w_rise && ((r_state == S_DATA) || ((r_state == S_CAL) && (r_per <= rtcal_cnt)));
        w_bit      = (r_per >= {1'b0, rtcal_cnt[15:1]});
        w_fb5      = w_bit ^ r_crc5[4];
        w_fb16     = w_bit ^ r_crc16[15];
        w_part     = r_byte << (4'd8 - {1'b0, r_bitcnt});
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dbus_out       <= '0;
            byte_valid     <= 1'b0;
            frame_start    <= 1'b0;
            frame_end      <= 1'b0;
            frame_err      <= 1'b0;
            frame_bits     <= '0;
            query_preamble <= 1'b0;
            rtcal_cnt      <= '0;
            trcal_cnt      <= '0;
            crc5_ok        <= 1'b0;
            crc16_ok       <= 1'b0;
            r_p0           <= '0;
            r_byte         <= '0;
            r_bitcnt       <= '0;
            r_crc5         <= '0;
            r_crc16        <= '0;
        end else begin
            byte_valid  <= 1'b0;
            frame_start <= w_start;
            frame_end   <= w_end;
            frame_err   <= w_err;
            if (w_start) begin
                frame_bits     <= '0;
                trcal_cnt      <= '0;
                query_preamble <= 1'b0;
                crc5_ok        <= 1'b0;
                crc16_ok       <= 1'b0;
                r_crc5         <= 5'b01001;
                r_crc16        <= 16'hFFFF;
                r_byte         <= '0;
                r_bitcnt       <= '0;
            end
            if (w_p0_ld)    r_p0      <= r_per;
            if (w_rtcal_ld) rtcal_cnt <= r_per;
            if (w_trcal) begin
                trcal_cnt      <= r_per;
                query_preamble <= 1'b1;
            end
            if (w_bit_en) begin
                r_byte   <= {r_byte[6:0], w_bit};
                r_bitcnt <= r_bitcnt + 3'd1;
                if (frame_bits != 16'hFFFF) frame_bits <= frame_bits + 16'd1;
                r_crc5   <= {r_crc5[3:0], 1'b0} ^ (w_fb5 ? 5'b01001 : 5'b00000);
                r_crc16  <= {r_crc16[14:0], 1'b0} ^ (w_fb16 ? 16'h1021 : 16'h0000);
                if (r_bitcnt == 3'd7) begin
                    dbus_out   <= {r_byte[6:0], w_bit};
                    byte_valid <= 1'b1;
                end
            end
            if (w_end) begin
                if (r_bitcnt != 3'd0) begin
                    dbus_out   <= w_part;
                    byte_valid <= 1'b1;
                end
                r_bitcnt <= '0;
                crc5_ok  <= (r_crc5 == 5'b00000);
                crc16_ok <= (r_crc16 == 16'h1D0F);
            end
            if (w_err) begin
                r_byte   <= '0;
                r_bitcnt <= '0;
                crc5_ok  <= 1'b0;
                crc16_ok <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pie_rx_decoder.sv
// Directed bench for pie_rx_decoder: frame vector table plus hand-built error and reset sequences.
module tb_pie_rx_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx = 1'b1;
    logic [7:0]  dbus_out;
    logic        byte_valid, frame_start, frame_end, frame_err;
    logic [15:0] frame_bits, rtcal_cnt, trcal_cnt;
    logic        query_preamble, crc5_ok, crc16_ok;

    always #5 clk = ~clk;

    pie_rx_decoder #(.DELIM_MIN(16'd40), .DELIM_MAX(16'd160), .MAX_CAL(16'd4095)) dut (
        .clk(clk), .reset(reset), .rx(rx),
        .dbus_out(dbus_out), .byte_valid(byte_valid),
        .frame_start(frame_start), .frame_end(frame_end), .frame_err(frame_err),
        .frame_bits(frame_bits), .query_preamble(query_preamble),
        .rtcal_cnt(rtcal_cnt), .trcal_cnt(trcal_cnt),
        .crc5_ok(crc5_ok), .crc16_ok(crc16_ok)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Event monitor: cumulative counters, sampled on the falling edge.
    int n_start = 0, n_end = 0, n_err = 0, n_bytes = 0, n_bvend = 0;
    logic [7:0] bytes_q [0:1023];
    always @(negedge clk) begin
        if (frame_start) n_start++;
        if (frame_end)   n_end++;
        if (frame_err)   n_err++;
        if (byte_valid) begin
            bytes_q[n_bytes & 1023] = dbus_out;
            n_bytes++;
        end
        if (byte_valid && frame_end) n_bvend++;
    end

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic sym(input int p);
        hold(1'b1, p - 10);
        hold(1'b0, 10);
    endtask

    task automatic send_frame(input int idle, input bit tr, input int p0, input int p1,
                              input int nb, input logic [31:0] bits);
        hold(1'b1, idle);
        hold(1'b0, 80);
        sym(40);
        sym(120);
        if (tr) sym(240);
        for (int i = 0; i < nb; i++) sym(bits[31 - i] ? p1 : p0);
        hold(1'b1, 200);
    endtask

    typedef struct {
        bit          tr;
        int          p0, p1, nb;
        logic [31:0] bits;
        int          nby;
        logic [31:0] eby;
        int          efb;
        bit          c5, e5, c16, e16;
    } vec_t;

    vec_t vecs [6];
    int s0, e0, r0, b0, be0;
    logic [31:0] tmp;

    initial begin
        // Query 1000_0_00_0_00_00_0_0000 + CRC-5 10000, with TRcal
        vecs[0] = '{1'b1, 40, 80, 22, 32'h80004000, 3, 32'h80004000, 22, 1'b1, 1'b1, 1'b0, 1'b0};
        // QueryRep 0000, frame-sync
        vecs[1] = '{1'b0, 40, 80, 4, 32'h00000000, 1, 32'h00000000, 4, 1'b0, 1'b0, 1'b0, 1'b0};
        // 0x0000 + inverted CRC-16 (0xE2F0)
        vecs[2] = '{1'b0, 40, 80, 32, 32'h0000E2F0, 4, 32'h0000E2F0, 32, 1'b0, 1'b0, 1'b1, 1'b1};
        // same with first payload bit flipped
        vecs[3] = '{1'b1, 40, 80, 32, 32'h8000E2F0, 4, 32'h8000E2F0, 32, 1'b0, 1'b0, 1'b1, 1'b0};
        // pivot: 59 -> 0, 60 -> 1
        vecs[4] = '{1'b0, 59, 60, 8, 32'h55000000, 1, 32'h55000000, 8, 1'b0, 1'b0, 1'b0, 1'b0};
        // 12 bits 0xABC -> AB, C0 partial
        vecs[5] = '{1'b1, 40, 80, 12, 32'hABC00000, 2, 32'hABC0_0000, 12, 1'b0, 1'b0, 1'b0, 1'b0};

        repeat (4) @(negedge clk);
        chk("reset_outputs", {dbus_out, byte_valid, frame_start, frame_end, frame_err, frame_bits,
             query_preamble, rtcal_cnt, trcal_cnt, crc5_ok, crc16_ok}, 32'h0);
        reset = 1'b1;
        hold(1'b1, 10);

        for (int v = 0; v < 6; v++) begin
            s0 = n_start; e0 = n_end; r0 = n_err; b0 = n_bytes; be0 = n_bvend;
            send_frame(20, vecs[v].tr, vecs[v].p0, vecs[v].p1, vecs[v].nb, vecs[v].bits);
            chk($sformatf("v%0d_start", v), n_start - s0, 1);
            chk($sformatf("v%0d_end", v), n_end - e0, 1);
            chk($sformatf("v%0d_err", v), n_err - r0, 0);
            chk($sformatf("v%0d_nbytes", v), n_bytes - b0, vecs[v].nby);
            tmp = vecs[v].eby;
            for (int k = 0; k < vecs[v].nby && k < 4; k++)
                chk($sformatf("v%0d_byte%0d", v, k), bytes_q[(b0 + k) & 1023], tmp[31 - 8*k -: 8]);
            chk($sformatf("v%0d_bv_with_end", v), n_bvend - be0, (vecs[v].nb % 8 != 0) ? 1 : 0);
            chk($sformatf("v%0d_frame_bits", v), frame_bits, vecs[v].efb);
            chk($sformatf("v%0d_qp", v), query_preamble, vecs[v].tr);
            chk($sformatf("v%0d_rtcal", v), rtcal_cnt, 120);
            chk($sformatf("v%0d_trcal", v), trcal_cnt, vecs[v].tr ? 240 : 0);
            if (vecs[v].c5)  chk($sformatf("v%0d_crc5", v), crc5_ok, vecs[v].e5);
            if (vecs[v].c16) chk($sformatf("v%0d_crc16", v), crc16_ok, vecs[v].e16);
        end

        // Short delimiter (30): error, then a frame starting 100 high cycles later is ignored.
        s0 = n_start; e0 = n_end; r0 = n_err; b0 = n_bytes;
        hold(1'b0, 30);
        send_frame(100, 1'b0, 40, 80, 4, 32'h0);
        chk("short_delim_err", n_err - r0, 1);
        chk("short_delim_nostart", n_start - s0, 0);
        chk("short_delim_noend", n_end - e0, 0);
        chk("short_delim_nobytes", n_bytes - b0, 0);

        // Long delimiter (200): error while low, then IDLE after 160 high, next frame accepted.
        s0 = n_start; e0 = n_end; r0 = n_err; b0 = n_bytes;
        hold(1'b0, 200);
        chk("long_delim_err", n_err - r0, 1);
        chk("long_delim_nostart", n_start - s0, 0);
        send_frame(170, 1'b0, 40, 80, 8, 32'hC3000000);
        chk("after_err_start", n_start - s0, 1);
        chk("after_err_end", n_end - e0, 1);
        chk("after_err_errcnt", n_err - r0, 1);
        chk("after_err_nbytes", n_bytes - b0, 1);
        chk("after_err_byte", bytes_q[b0 & 1023], 8'hC3);

        // Reset mid-DATA after 5 bits.
        r0 = n_err;
        hold(1'b1, 20);
        hold(1'b0, 80);
        sym(40);
        sym(120);
        sym(80); sym(40); sym(80); sym(80); sym(40);
        hold(1'b1, 10);
        chk("pre_reset_bits", frame_bits, 5);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_reset_outputs", {dbus_out, byte_valid, frame_start, frame_end, frame_err, frame_bits,
             query_preamble, rtcal_cnt, trcal_cnt, crc5_ok, crc16_ok}, 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        hold(1'b1, 20);
        chk("reset_no_err", n_err - r0, 0);
        s0 = n_start; e0 = n_end; b0 = n_bytes;
        send_frame(20, 1'b0, 40, 80, 8, 32'hA5000000);
        chk("post_reset_start", n_start - s0, 1);
        chk("post_reset_end", n_end - e0, 1);
        chk("post_reset_nbytes", n_bytes - b0, 1);
        chk("post_reset_byte", bytes_q[b0 & 1023], 8'hA5);
        chk("post_reset_bits", frame_bits, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
